// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache: same-cycle hits, burst line refill on miss.
// Ports: cpu_* fetch side, mem_* refill side, flush = fence.i; ICACHE_STATS_EN adds hit/miss counters.
module icache_dm #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_valid,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(NUM_LINES);
  localparam int OFF = WB + 2;
  localparam int TW  = ADDR_W - OFF - IB;
  localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       data_q [NUM_LINES*LINE_WORDS];
  logic [TW-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [ADDR_W-1:0] miss_q;
  logic [WB-1:0]     cnt_q;
  logic              pend_q;

  logic [IB-1:0] idx, m_idx;
  logic [WB-1:0] wsel;
  logic [TW-1:0] tag, m_tag;
  logic          hit;
  logic          latch;
  logic          beat;
  logic          last;
  logic          unused_lo;

  assign unused_lo = ^cpu_addr[1:0];

  assign wsel  = cpu_addr[OFF-1:2];
  assign idx   = cpu_addr[OFF+IB-1:OFF];
  assign tag   = cpu_addr[ADDR_W-1:OFF+IB];
  assign m_idx = miss_q[OFF+IB-1:OFF];
  assign m_tag = miss_q[ADDR_W-1:OFF+IB];

  assign hit = (state_q == S_IDLE) & cpu_req &
               valid_q[idx] & (tag_q[idx] == tag);

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    latch   = 1'b0;
    beat    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req & ~hit) begin
          latch   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_rvalid) begin
          beat = 1'b1;
          if (cnt_q == LAST) begin
            last    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = mem_req ? {miss_q[ADDR_W-1:OFF], {OFF{1'b0}}}
                             : '0;
  assign cpu_valid = hit;
  assign cpu_rdata = hit ? data_q[{idx, wsel}] : 32'd0;
  // Stall is forced low while reset is held, even with cpu_req up.
  assign cpu_stall = ~rst &
                     ((state_q != S_IDLE) | (cpu_req & ~hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) miss_q <= cpu_addr;
      if (state_q == S_REQ) cnt_q <= '0;
      else if (beat) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_IDLE) begin
        if (flush) valid_q <= '0;
      end else if (last) begin
        // A flush seen during the refill drops every line,
        // including the one just filled.
        if (pend_q | flush) valid_q <= '0;
        else valid_q[m_idx] <= 1'b1;
        pend_q <= 1'b0;
      end else if (flush) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) data_q[{m_idx, cnt_q}] <= mem_rdata;
    if (last) tag_q[m_idx] <= m_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      if (latch) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with default geometry (64 lines x 4 words).
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_valid  (cpu_valid),
    .cpu_stall  (cpu_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Miss at addr, optional mem_ready wait, four beats, optional flush
  // on beat flush_at. Core address wanders during the fill.
  task automatic miss_fill(input logic [31:0] addr, input int waitc,
                           input logic [3:0][31:0] w, input int flush_at);
    logic [31:0] la;
    la = addr & 32'hFFFF_FFF0;
    cpu_req = 1'b1;
    cpu_addr = addr;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({cpu_stall, cpu_valid, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL miss_detect @%h: stall/valid/req=%b want 100",
               addr, {cpu_stall, cpu_valid, mem_req});
    end
    step();
    for (int i = 0; i < waitc; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_chk++;
      if ({mem_req, cpu_stall, mem_addr} !== {2'b11, la}) begin
        n_fail++;
        $display("FAIL req_hold[%0d]: req=%b stall=%b addr=%h want 1 1 %h",
                 i, mem_req, cpu_stall, mem_addr, la);
      end
      step();
    end
    mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mem_req, mem_addr} !== {1'b1, la}) begin
      n_fail++;
      $display("FAIL req_accept: req=%b addr=%h want 1 %h",
               mem_req, mem_addr, la);
    end
    step();
    mem_ready = 1'b0;
    cpu_addr = addr ^ 32'h0000_8000;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = w[i];
      flush = (i == flush_at);
      @(negedge clk);
      n_chk++;
      if ({cpu_stall, cpu_valid, mem_req} !== 3'b100) begin
        n_fail++;
        $display("FAIL fill_beat[%0d]: stall/valid/req=%b want 100",
                 i, {cpu_stall, cpu_valid, mem_req});
      end
      step();
    end
    flush = 1'b0;
    mem_rvalid = 1'b0;
    cpu_addr = addr;
  endtask

  task automatic check_hit(input logic [31:0] addr, input logic [31:0] exp);
    cpu_req = 1'b1;
    cpu_addr = addr;
    @(negedge clk);
    n_chk++;
    if ({cpu_valid, cpu_stall, mem_req, cpu_rdata} !== {3'b100, exp}) begin
      n_fail++;
      $display("FAIL hit @%h: v/s/r=%b data=%h want 100 %h", addr,
               {cpu_valid, cpu_stall, mem_req}, cpu_rdata, exp);
    end
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h8;
    flush = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    n_chk++;
    if ({cpu_stall, cpu_valid, mem_req, mem_addr, cpu_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset: s/v/r=%b addr=%h data=%h want all 0",
               {cpu_stall, cpu_valid, mem_req}, mem_addr, cpu_rdata);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_cold_miss;
    miss_fill(32'h8, 0, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
    check_hit(32'h8, 32'h33);
    check_hit(32'hC, 32'h44);
    check_hit(32'h0, 32'h11);
  endtask

  task automatic test_conflict;
    miss_fill(32'h400, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1);
    check_hit(32'h404, 32'hA1);
    miss_fill(32'h0, 0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1);
    check_hit(32'h0, 32'hB0);
    check_hit(32'hC, 32'hB3);
  endtask

  task automatic test_backpressure;
    miss_fill(32'h1234, 5, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1);
    check_hit(32'h1234, 32'hC1);
    check_hit(32'h1230, 32'hC0);
  endtask

  task automatic test_flush;
    miss_fill(32'h2000, 0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 2);
    miss_fill(32'h2000, 0, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, -1);
    check_hit(32'h2008, 32'hE2);
    miss_fill(32'h1234, 0, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, -1);
    miss_fill(32'h0, 0, {32'h13, 32'h12, 32'h11, 32'h10}, -1);
    check_hit(32'h4, 32'h11);
    flush = 1'b1;
    check_hit(32'h0, 32'h10);
    flush = 1'b0;
    miss_fill(32'h0, 0, {32'h23, 32'h22, 32'h21, 32'h20}, -1);
    check_hit(32'h0, 32'h20);
  endtask

  task automatic test_reset_mid;
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'h77;
      step();
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mem_req, cpu_stall, cpu_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: req/stall/valid=%b want 000",
               {mem_req, cpu_stall, cpu_valid});
    end
    step();
    rst = 1'b0;
    miss_fill(32'h0, 0, {32'h33, 32'h32, 32'h31, 32'h30}, -1);
    check_hit(32'h8, 32'h32);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    step();
    rst = 1'b0;
    miss_fill(32'h0, 0, {32'h53, 32'h52, 32'h51, 32'h50}, -1);
    check_hit(32'h4, 32'h51);
    check_hit(32'h8, 32'h52);
    miss_fill(32'h400, 0, {32'h63, 32'h62, 32'h61, 32'h60}, -1);
    check_hit(32'h404, 32'h61);
    cpu_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({hit_count, miss_count} !== {32'd3, 32'd2}) begin
      n_fail++;
      $display("FAIL stats: hit=%0d miss=%0d want 3 2",
               hit_count, miss_count);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    cpu_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core fetch stage (`pc_addr`/`instr`) and a multi-cycle backing instruction memory.
- Hits return the instruction in the same cycle.
- Misses stall fetch while a line-aligned burst refill runs.
- Replaces the core's direct combinational imem path so that slower memories can be used.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_rdata  out  32  instruction word; meaningful only when cpu_valid=1.
- cpu_valid  out  1  hit this cycle; cpu_rdata is valid.
- cpu_stall  out  1  fetch must hold its PC.
- flush  in  1  invalidate all lines (fence.i).
- mem_req  out  1  refill burst request.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  refill data beat valid.
- mem_rdata  in  32  refill data beat.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2.
  - Word select = cpu_addr[OFF-1:2].
  - Index = cpu_addr[OFF+log2(NUM_LINES)-1:OFF].
  - Tag = remaining upper bits.
  - Defaults give word [3:2], index [9:4], tag [31:10].
- Storage: valid bit, tag and data per line, held in flops or distributed RAM with asynchronous read.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - hit = cpu_req & valid[idx] & (tag match).
  - cpu_valid = hit.
  - cpu_rdata = data[idx][word], combinational, zero added latency.
  - On cpu_req & ~hit: latch the miss address and go to REQ. cpu_stall=1 in that same cycle.
- REQ:
  - mem_req=1 and mem_addr = latched address with bits [OFF-1:0]=0.
  - mem_req and mem_addr stay stable until mem_ready=1, then go to FILL with beat counter=0.
- FILL:
  - Each mem_rvalid writes mem_rdata into word[counter] of the latched line, then counter increments.
  - The beat with counter=LINE_WORDS-1 writes the tag and sets valid, then returns to IDLE.
  - mem_rvalid outside FILL is ignored.
- cpu_stall = (state!=IDLE) | (cpu_req & ~hit).
- cpu_valid=0 whenever state!=IDLE.
- Re-lookup: the first IDLE cycle after a refill performs a fresh lookup of the current cpu_addr. Minimum miss penalty = 1 + mem_ready wait + LINE_WORDS beats + 1 cycle.
- Core address changes during a refill are allowed. The refill always completes for the latched address.
- flush:
  - In IDLE: clears all valid bits at the clock edge. A lookup in the same cycle uses the pre-flush valid bits.
  - In REQ/FILL: sets flush_pending. The refill completes without setting valid. All valid bits clear on return to IDLE, then flush_pending clears.
- Reset:
  - State, valid bits, counter and flush_pending clear immediately.
  - cpu_stall=0, cpu_valid=0, mem_req=0, mem_addr=0.
  - cpu_rdata=0 while no hit.
  - Reset mid-refill abandons the burst. The bench or memory must also reset.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count, 32 bits each.
  - hit_count increments on each IDLE cycle with hit=1.
  - miss_count increments on each IDLE→REQ transition.
  - Both wrap at 2^32 and clear only on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after rst, cpu_req with cpu_addr=0x8; mem_ready same cycle; beats 0x11,0x22,0x33,0x44.
  - Response: mem_addr=0x0; cpu_stall high through the refill; next IDLE cycle cpu_valid=1, cpu_rdata=0x33.
  - Follow-up: cpu_addr=0xC gives a hit with 0x44 and no mem_req.
- Conflict:
  - Stimulus: fill 0x0, then access 0x400 (index 0, new tag), then 0x0 again.
  - Response: two additional refills, each with its correct mem_addr; data correct after each.
- Backpressure:
  - Stimulus: hold mem_ready=0 for 5 cycles on a miss at 0x1234.
  - Response: mem_req=1 and mem_addr=0x1230 held stable all 5 cycles; no beats are consumed before acceptance.
- Flush:
  - Stimulus: pulse flush in FILL after beat 1, then re-access the same address after return to IDLE.
  - Response: that access misses; a separate flush in IDLE makes a previously hitting 0x0 miss.
- Reset mid-refill:
  - Stimulus: assert rst after 2 beats.
  - Response: mem_req=0 and cpu_stall=0 immediately; after release, 0x0 misses.
- Stats (with ICACHE_STATS_EN):
  - Stimulus: sequence 0x0 miss, 0x4 hit, 0x8 hit, 0x400 miss, 0x404 hit.
  - Response: hit_count=3, miss_count=2.
